// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud divisor, optional parity, 1/2 stop bits and
// three-sample mid-bit voting; reports parity/framing/break/overrun status.
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  perr,
  output logic                  ferr,
  output logic                  brk,
  output logic                  valid,
  input  logic                  ready,
  output logic                  ovr,
  input  logic                  ovr_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(4);
  localparam logic [3:0]           LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);

  state_t state, state_n;

  logic                  rx_meta, rx_s, rx_prev;
  logic [1:0]            live;
  logic                  armed;
  logic [DIV_WIDTH-1:0]  div_q, cnt;
  logic [DIV_WIDTH-1:0]  half, half_m1, half_p1, div_last;
  logic                  v0, v1, vote;
  logic                  at_s0, at_s1, at_dec;
  logic                  start_edge;
  logic [3:0]            bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  ferr_acc;
  logic                  frame_done;
  logic                  par_x, perr_new, ferr_new, brk_new;

  always_comb begin
    half     = div_q >> 1;
    half_m1  = half - ONE;
    half_p1  = half + ONE;
    div_last = div_q - ONE;
    at_s0    = (cnt == half_m1);
    at_s1    = (cnt == half);
    at_dec   = (cnt == half_p1);
    vote     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    // armed only once a genuine high has been seen after reset, so a line
    // already low at reset release is not taken as a start bit
    start_edge = armed & rx_prev & ~rx_s;
    par_x    = (^shreg) ^ par_bit;
    perr_new = (PARITY == 2) ? par_x : ((PARITY == 1) ? ~par_x : 1'b0);
    ferr_new = ferr_acc | ~vote;
    brk_new  = ferr_new & (shreg == '0) & ~par_bit;
  end

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:      if (start_edge) state_n = S_START;
      S_START:     if (at_dec) state_n = vote ? S_IDLE : S_DATA;
      S_DATA:      if (at_dec && bit_idx == LAST_DATA)
                     state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (at_dec) state_n = S_STOP;
      S_STOP: begin
        if (at_dec && bit_idx == LAST_STOP) begin
          frame_done = 1'b1;
          state_n    = ferr_new ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: if (rx_s) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      live     <= '0;
      armed    <= 1'b0;
      div_q    <= DIV_MIN;
      cnt      <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      data     <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk      <= 1'b0;
      valid    <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      live    <= {live[0], 1'b1};
      if (live[1] && rx_s) armed <= 1'b1;

      state <= state_n;

      // the detection cycle counts as count 0 of the start bit
      if (state == S_IDLE) begin
        if (start_edge) begin
          div_q <= (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
          cnt   <= ONE;
        end
      end else if (state != S_WAIT_HIGH) begin
        cnt <= (cnt == div_last) ? '0 : cnt + ONE;
      end

      if (at_s0) v0 <= rx_s;
      if (at_s1) v1 <= rx_s;

      if (at_dec) begin
        case (state)
          S_START: begin
            bit_idx  <= '0;
            ferr_acc <= 1'b0;
            par_bit  <= 1'b0;
          end
          S_DATA: begin
            shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
            bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 4'd1;
          end
          S_PARITY: par_bit <= vote;
          S_STOP: begin
            if (!vote) ferr_acc <= 1'b1;
            bit_idx <= bit_idx + 4'd1;
          end
          default: ;
        endcase
      end

      if (valid && ready) valid <= 1'b0;
      if (ovr_clr) ovr <= 1'b0;
      // a completed frame is dropped while a word is held, even if it is
      // being accepted this same cycle
      if (frame_done) begin
        if (valid) begin
          ovr <= 1'b1;
        end else begin
          data  <= shreg;
          perr  <= perr_new;
          ferr  <= ferr_new;
          brk   <= brk_new;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: an 8N1 and a 7E2 instance driven with
// ideal-timed frames and compared against a frame-level reference model.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;

  logic       rx8, ready8, ovr_clr8;
  logic [7:0] data8;
  logic       perr8, ferr8, brk8, valid8, ovr8;

  logic       rx7, ready7, ovr_clr7;
  logic [6:0] data7;
  logic       perr7, ferr7, brk7, valid7, ovr7;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) u8 (
    .clk(clk), .rst(rst), .rx(rx8), .baud_div(baud_div), .data(data8),
    .perr(perr8), .ferr(ferr8), .brk(brk8), .valid(valid8), .ready(ready8),
    .ovr(ovr8), .ovr_clr(ovr_clr8)
  );

  uart_rx_cfg #(.DATA_WIDTH(7), .PARITY(2), .STOP_BITS(2), .DIV_WIDTH(16)) u7 (
    .clk(clk), .rst(rst), .rx(rx7), .baud_div(baud_div), .data(data7),
    .perr(perr7), .ferr(ferr7), .brk(brk7), .valid(valid7), .ready(ready7),
    .ovr(ovr7), .ovr_clr(ovr_clr7)
  );

  // accepted words packed as {brk, ferr, perr, data[8:0]}
  logic [11:0] q8[$];
  logic [11:0] q7[$];
  int nrise8 = 0, vhigh8 = 0, rise8 = 0;
  logic pv8 = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid8 && ready8) q8.push_back({brk8, ferr8, perr8, 1'b0, data8});
      if (valid7 && ready7) q7.push_back({brk7, ferr7, perr7, 2'b00, data7});
      if (valid8 && !pv8) begin
        nrise8 = nrise8 + 1;
        rise8  = cyc;
      end
      if (valid8) vhigh8 = vhigh8 + 1;
    end
    pv8 = valid8;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int eff(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  // reference: status derived straight from the frame contents
  function automatic logic [11:0] expect_word(input int dw, input int par,
                                              input logic [8:0] d, input logic pbit,
                                              input logic stop_ok);
    logic [8:0] mask;
    logic [8:0] dm;
    int         ones;
    logic       pe, fe, bk;
    mask = 9'h1;
    mask = (mask << dw) - 9'h1;
    dm   = d & mask;
    ones = $countones(dm) + int'(pbit);
    if (par == 0)      pe = 1'b0;
    else if (par == 2) pe = (ones % 2) == 1;
    else               pe = (ones % 2) == 0;
    fe = !stop_ok;
    bk = fe && (dm == 9'h0) && (par == 0 || pbit == 1'b0);
    return {bk, fe, pe, dm};
  endfunction

  task automatic drive(input int which, input logic v);
    if (which == 8) rx8 = v;
    else            rx7 = v;
  endtask

  task automatic hold(input int which, input logic v, input int n);
    drive(which, v);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int which, input int dw, input int par, input int nstop,
                            input logic [8:0] d, input logic pbit, input logic stop_val,
                            input int cpb);
    hold(which, 1'b0, cpb);
    for (int i = 0; i < dw; i++) hold(which, d[i], cpb);
    if (par != 0) hold(which, pbit, cpb);
    for (int s = 0; s < nstop; s++) hold(which, stop_val, cpb);
  endtask

  task automatic test_reset();
    tests++;
    if (data8 !== 8'h00) begin fails++; $display("FAIL reset_data8: got %h want 00", data8); end
    tests++;
    if ({perr8, ferr8, brk8} !== 3'b000) begin
      fails++; $display("FAIL reset_flags8: got %b want 000", {perr8, ferr8, brk8});
    end
    tests++;
    if (valid8 !== 1'b0) begin fails++; $display("FAIL reset_valid8: got %b want 0", valid8); end
    tests++;
    if (ovr8 !== 1'b0) begin fails++; $display("FAIL reset_ovr8: got %b want 0", ovr8); end
    tests++;
    if ({valid7, ovr7, data7} !== 9'h000) begin
      fails++; $display("FAIL reset_u7: got %h want 000", {valid7, ovr7, data7});
    end
  endtask

  task automatic test_a5_timing();
    int          c0;
    logic [11:0] e;
    baud_div = 16'd16;
    ready8 = 1'b1;
    q8.delete();
    nrise8 = 0;
    vhigh8 = 0;
    c0 = cyc;
    send_frame(8, 8, 0, 1, 9'h0A5, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 20);
    e = expect_word(8, 0, 9'h0A5, 1'b0, 1'b1);
    // start detected 3 edges after the pin; last stop bit 9 decided at
    // T0 + 9*16 + 8 + 1; valid visible one edge later
    tests++;
    if (rise8 !== c0 + 3 + 9 * 16 + 8 + 1) begin
      fails++; $display("FAIL a5_rise_cycle: got %0d want %0d", rise8 - c0, 3 + 9 * 16 + 9);
    end
    tests++;
    if (nrise8 !== 1 || vhigh8 !== 1) begin
      fails++; $display("FAIL a5_pulse: got rises %0d high %0d want 1 1", nrise8, vhigh8);
    end
    tests++;
    if (q8.size() !== 1) begin
      fails++; $display("FAIL a5_count: got %0d want 1", q8.size());
    end else if (q8[0] !== e) begin
      fails++; $display("FAIL a5_word: got %h want %h", q8[0], e);
    end
  endtask

  task automatic test_parity();
    logic [11:0] exp_q[$];
    logic [8:0]  d;
    logic        p;
    int          bd;
    ready7 = 1'b1;
    q7.delete();
    baud_div = 16'd10;
    send_frame(7, 7, 2, 2, 9'h041, 1'b1, 1'b1, 10);
    hold(7, 1'b1, 20);
    exp_q.push_back(expect_word(7, 2, 9'h041, 1'b1, 1'b1));
    send_frame(7, 7, 2, 2, 9'h041, 1'b0, 1'b1, 10);
    hold(7, 1'b1, 20);
    exp_q.push_back(expect_word(7, 2, 9'h041, 1'b0, 1'b1));
    tests++;
    if (q7.size() < 2 || q7[0][9] !== 1'b1 || q7[1][9] !== 1'b0) begin
      fails++; $display("FAIL parity_0x41: got n=%0d w0=%h w1=%h want perr 1 then 0",
                        q7.size(), (q7.size() > 0) ? q7[0] : 12'h0, (q7.size() > 1) ? q7[1] : 12'h0);
    end
    for (int i = 0; i < 6; i++) begin
      d  = 9'($urandom_range(0, 127));
      p  = 1'($urandom);
      bd = $urandom_range(2, 12);
      baud_div = 16'(bd);
      send_frame(7, 7, 2, 2, d, p, 1'b1, eff(bd));
      hold(7, 1'b1, 2 * eff(bd));
      exp_q.push_back(expect_word(7, 2, d, p, 1'b1));
    end
    tests++;
    if (q7.size() !== exp_q.size()) begin
      fails++; $display("FAIL parity_count: got %0d want %0d", q7.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (q7[i] !== exp_q[i]) begin
          fails++; $display("FAIL parity_word%0d: got %h want %h", i, q7[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_break();
    logic [11:0] e0, e1;
    baud_div = 16'd16;
    ready8 = 1'b1;
    q8.delete();
    nrise8 = 0;
    send_frame(8, 8, 0, 1, 9'h000, 1'b0, 1'b0, 16);
    hold(8, 1'b0, 40 * 16);
    e0 = expect_word(8, 0, 9'h000, 1'b0, 1'b0);
    tests++;
    if (nrise8 !== 1 || q8.size() !== 1) begin
      fails++; $display("FAIL break_single: got rises %0d words %0d want 1 1", nrise8, q8.size());
    end else if (q8[0] !== e0) begin
      fails++; $display("FAIL break_word: got %h want %h", q8[0], e0);
    end
    hold(8, 1'b1, 32);
    send_frame(8, 8, 0, 1, 9'h096, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 20);
    e1 = expect_word(8, 0, 9'h096, 1'b0, 1'b1);
    tests++;
    if (q8.size() !== 2) begin
      fails++; $display("FAIL break_recover_count: got %0d want 2", q8.size());
    end else if (q8[1] !== e1) begin
      fails++; $display("FAIL break_recover_word: got %h want %h", q8[1], e1);
    end
  endtask

  task automatic test_glitch();
    logic [11:0] e;
    baud_div = 16'd16;
    ready8 = 1'b1;
    q8.delete();
    nrise8 = 0;
    hold(8, 1'b0, 1);
    hold(8, 1'b1, 60);
    tests++;
    if (nrise8 !== 0) begin
      fails++; $display("FAIL glitch_no_valid: got %0d words want 0", nrise8);
    end
    send_frame(8, 8, 0, 1, 9'h03C, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 20);
    e = expect_word(8, 0, 9'h03C, 1'b0, 1'b1);
    tests++;
    if (q8.size() !== 1) begin
      fails++; $display("FAIL glitch_next_count: got %0d want 1", q8.size());
    end else if (q8[0] !== e) begin
      fails++; $display("FAIL glitch_next_word: got %h want %h", q8[0], e);
    end
  endtask

  task automatic test_overrun();
    baud_div = 16'd16;
    ready8 = 1'b0;
    send_frame(8, 8, 0, 1, 9'h011, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 16);
    send_frame(8, 8, 0, 1, 9'h022, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 20);
    tests++;
    if ({valid8, ovr8, data8} !== {1'b1, 1'b1, 8'h11}) begin
      fails++; $display("FAIL ovr_hold: got valid %b ovr %b data %h want 1 1 11", valid8, ovr8, data8);
    end
    ready8 = 1'b1;
    @(posedge clk); #1;
    ready8 = 1'b0;
    tests++;
    if (valid8 !== 1'b0 || ovr8 !== 1'b1) begin
      fails++; $display("FAIL ovr_accept: got valid %b ovr %b want 0 1", valid8, ovr8);
    end
    ovr_clr8 = 1'b1;
    @(posedge clk); #1;
    ovr_clr8 = 1'b0;
    tests++;
    if (ovr8 !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", ovr8); end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] e;
    baud_div = 16'd16;
    ready8 = 1'b0;
    send_frame(8, 8, 0, 1, 9'h0C3, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 16);
    send_frame(8, 8, 0, 1, 9'h03F, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 20);
    // partial 0x5A: start + bits 0..3, then reset while the line is low
    hold(8, 1'b0, 16);
    hold(8, 1'b0, 16);
    hold(8, 1'b1, 16);
    hold(8, 1'b0, 16);
    hold(8, 1'b1, 16);
    hold(8, 1'b0, 8);
    rst = 1'b1;
    hold(8, 1'b0, 3);
    tests++;
    if ({valid8, ovr8, perr8, ferr8, brk8, data8} !== 13'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got valid %b ovr %b flags %b data %h want all 0",
                        valid8, ovr8, {perr8, ferr8, brk8}, data8);
    end
    rst = 1'b0;
    q8.delete();
    nrise8 = 0;
    hold(8, 1'b0, 64);
    ready8 = 1'b1;
    hold(8, 1'b1, 32);
    tests++;
    if (nrise8 !== 0) begin
      fails++; $display("FAIL rst_mid_no_word: got %0d words want 0", nrise8);
    end
    send_frame(8, 8, 0, 1, 9'h05A, 1'b0, 1'b1, 16);
    hold(8, 1'b1, 20);
    e = expect_word(8, 0, 9'h05A, 1'b0, 1'b1);
    tests++;
    if (q8.size() !== 1) begin
      fails++; $display("FAIL rst_mid_next_count: got %0d want 1", q8.size());
    end else if (q8[0] !== e) begin
      fails++; $display("FAIL rst_mid_next_word: got %h want %h", q8[0], e);
    end
  endtask

  task automatic test_back_to_back();
    int          divs[3];
    logic [11:0] exp_q[$];
    logic [8:0]  d;
    divs[0] = 3;
    divs[1] = 5;
    divs[2] = 16;
    ready8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      baud_div = 16'(divs[k]);
      q8.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
        d = 9'($urandom_range(0, 255));
        send_frame(8, 8, 0, 1, d, 1'b0, 1'b1, eff(divs[k]));
        exp_q.push_back(expect_word(8, 0, d, 1'b0, 1'b1));
      end
      hold(8, 1'b1, 2 * eff(divs[k]) + 8);
      tests++;
      if (q8.size() !== exp_q.size()) begin
        fails++; $display("FAIL b2b_count_div%0d: got %0d want %0d", divs[k], q8.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests++;
          if (q8[i] !== exp_q[i]) begin
            fails++; $display("FAIL b2b_word_div%0d_%0d: got %h want %h", divs[k], i, q8[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    baud_div = 16'd16;
    rx8      = 1'b1;
    rx7      = 1'b1;
    ready8   = 1'b0;
    ready7   = 1'b0;
    ovr_clr8 = 1'b0;
    ovr_clr7 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(8, 1'b1, 10);
    test_reset();
    test_a5_timing();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
